// File: rtl/reg_file.sv
// Architectural register file: two combinational operand read ports with write-first
// bypass, one write-back port, a bypass-free debug read port and a committed-write counter.

module reg_file_rd_port #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         byp_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_val,
  input  logic [NREG-1:0][DATA_W-1:0]  rf,
  output logic [DATA_W-1:0]            val
);
  // r0 wins over the bypass so a write aimed at r0 never leaks through
  always_comb begin
    val = '0;
    if (addr != '0) begin
      if (byp_en && (wr_addr == addr)) val = wr_val;
      else                             val = rf[addr];
    end
  end
endmodule

module reg_file #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_readAddrLeft,
  input  logic [ADDR_W-1:0] i_readAddrRight,
  output logic [DATA_W-1:0] o_readVall,
  output logic [DATA_W-1:0] o_readValr,
  input  logic              i_writeEnable,
  input  logic [ADDR_W-1:0] i_writeAddr,
  input  logic [DATA_W-1:0] i_writeVal,
  input  logic [ADDR_W-1:0] i_dbgAddr,
  output logic [DATA_W-1:0] o_dbgVal,
  output logic [CNT_W-1:0]  o_writeCount
);
  localparam int NREG = 2**ADDR_W;
  localparam int NRD  = 3;

  logic [NREG-1:1][DATA_W-1:0] mem;
  logic [NREG-1:0][DATA_W-1:0] rf;
  logic                        wr_commit;
  logic                        byp_live;

  // r0 has no storage; it is spliced in as a constant zero row
  assign rf        = {mem, {DATA_W{1'b0}}};
  assign byp_live  = !rst && i_writeEnable;
  assign wr_commit = byp_live && (i_writeAddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem          <= '0;
      o_writeCount <= '0;
    end else if (wr_commit) begin
      for (int i = 1; i < NREG; i++)
        if (i_writeAddr == ADDR_W'(i)) mem[i] <= i_writeVal;
      o_writeCount <= o_writeCount + CNT_W'(1);
    end
  end

  // lanes 0/1 are the operand ports, lane 2 is debug with bypass tied off
  logic [NRD-1:0][ADDR_W-1:0] rd_addr;
  logic [NRD-1:0]             rd_byp;
  logic [NRD-1:0][DATA_W-1:0] rd_val;

  assign rd_addr = {i_dbgAddr, i_readAddrRight, i_readAddrLeft};
  assign rd_byp  = {1'b0, byp_live, byp_live};

  generate
    for (genvar g = 0; g < NRD; g++) begin : g_rd
      reg_file_rd_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NREG   (NREG)
      ) u_rd (
        .addr    (rd_addr[g]),
        .byp_en  (rd_byp[g]),
        .wr_addr (i_writeAddr),
        .wr_val  (i_writeVal),
        .rf      (rf),
        .val     (rd_val[g])
      );
    end
  endgenerate

  assign o_readVall = rd_val[0];
  assign o_readValr = rd_val[1];
  assign o_dbgVal   = rd_val[2];
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expected values are queued as stimulus is driven
// and popped against the DUT outputs; CNT_W=4 so the counter wrap is reachable.

module tb_reg_file;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] la, ra, wa, da;
  logic          we;
  logic [DW-1:0] wv;
  logic [DW-1:0] vall, valr, dbgv;
  logic [CW-1:0] wcnt;

  logic [DW-1:0] mdl [32];
  logic [31:0]   mcnt;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_v;
  int            checks = 0;
  int            errors = 0;

  reg_file #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_readAddrLeft  (la),
    .i_readAddrRight (ra),
    .o_readVall      (vall),
    .o_readValr      (valr),
    .i_writeEnable   (we),
    .i_writeAddr     (wa),
    .i_writeVal      (wv),
    .i_dbgAddr       (da),
    .o_dbgVal        (dbgv),
    .o_writeCount    (wcnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_commit();
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      mcnt = 0;
    end else if (we && wa != 0) begin
      mdl[wa] = wv;
      mcnt    = mcnt + 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; wa = '0; wv = '0; la = '0; ra = '0; da = '0;
    step(); step();
    model_commit();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      la = AW'(a); ra = AW'(31 - a); da = AW'(a);
      sb.push_back(mdl[a]); sb.push_back(mdl[31 - a]); sb.push_back(mdl[a]);
      #1;
      exp_v = sb.pop_front(); checks++;
      if (vall !== exp_v) begin errors++; $display("FAIL reset_left a=%0d got %h exp %h", a, vall, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (valr !== exp_v) begin errors++; $display("FAIL reset_right a=%0d got %h exp %h", a, valr, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (dbgv !== exp_v) begin errors++; $display("FAIL reset_dbg a=%0d got %h exp %h", a, dbgv, exp_v); end
    end
    sb.push_back(DW'(mcnt[CW-1:0]));
    exp_v = sb.pop_front(); checks++;
    if (DW'(wcnt) !== exp_v) begin errors++; $display("FAIL reset_count got %h exp %h", wcnt, exp_v); end
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 5'd5; wv = 32'hDEADBEEF;
    step(); model_commit();
    we = 1'b0; la = 5'd5; ra = 5'd5; da = 5'd5;
    sb.push_back(mdl[5]); sb.push_back(mdl[5]); sb.push_back(mdl[5]); sb.push_back(DW'(mcnt[CW-1:0]));
    #1;
    exp_v = sb.pop_front(); checks++;
    if (vall !== exp_v) begin errors++; $display("FAIL wr_left got %h exp %h", vall, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (valr !== exp_v) begin errors++; $display("FAIL wr_right got %h exp %h", valr, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (dbgv !== exp_v) begin errors++; $display("FAIL wr_dbg got %h exp %h", dbgv, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (DW'(wcnt) !== exp_v) begin errors++; $display("FAIL wr_count got %h exp %h", wcnt, exp_v); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd7; wv = 32'h12345678; la = 5'd7; ra = 5'd5; da = 5'd7;
    sb.push_back(wv); sb.push_back(mdl[5]); sb.push_back(mdl[7]);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (vall !== exp_v) begin errors++; $display("FAIL byp_left got %h exp %h", vall, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (valr !== exp_v) begin errors++; $display("FAIL byp_right got %h exp %h", valr, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (dbgv !== exp_v) begin errors++; $display("FAIL byp_dbg_old got %h exp %h", dbgv, exp_v); end
    step(); model_commit();
    // both ports hit the bypass on the same register
    wa = 5'd9; wv = 32'hCAFEF00D; la = 5'd9; ra = 5'd9;
    sb.push_back(mdl[7]); sb.push_back(wv); sb.push_back(wv);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (dbgv !== exp_v) begin errors++; $display("FAIL byp_dbg_new got %h exp %h", dbgv, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (vall !== exp_v) begin errors++; $display("FAIL dual_byp_left got %h exp %h", vall, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (valr !== exp_v) begin errors++; $display("FAIL dual_byp_right got %h exp %h", valr, exp_v); end
    step(); model_commit();
    we = 1'b0;
  endtask

  task automatic test_r0();
    we = 1'b1; wa = 5'd0; wv = 32'hFFFFFFFF; la = 5'd0; ra = 5'd0; da = 5'd0;
    sb.push_back(32'h0); sb.push_back(32'h0);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (vall !== exp_v) begin errors++; $display("FAIL r0_byp_left got %h exp %h", vall, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (valr !== exp_v) begin errors++; $display("FAIL r0_byp_right got %h exp %h", valr, exp_v); end
    step(); model_commit();
    we = 1'b0;
    sb.push_back(mdl[0]); sb.push_back(mdl[0]); sb.push_back(DW'(mcnt[CW-1:0]));
    #1;
    exp_v = sb.pop_front(); checks++;
    if (vall !== exp_v) begin errors++; $display("FAIL r0_after got %h exp %h", vall, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (dbgv !== exp_v) begin errors++; $display("FAIL r0_dbg got %h exp %h", dbgv, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (DW'(wcnt) !== exp_v) begin errors++; $display("FAIL r0_count got %h exp %h", wcnt, exp_v); end
  endtask

  task automatic test_reset_write();
    rst = 1'b1; we = 1'b1; wa = 5'd3; wv = 32'hA5A5A5A5; la = 5'd3; ra = 5'd3; da = 5'd5;
    // bypass is off during reset: ports show array contents
    sb.push_back(mdl[3]); sb.push_back(mdl[3]);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (vall !== exp_v) begin errors++; $display("FAIL rst_nobyp_left got %h exp %h", vall, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (valr !== exp_v) begin errors++; $display("FAIL rst_nobyp_right got %h exp %h", valr, exp_v); end
    step(); model_commit();
    rst = 1'b0; we = 1'b0;
    sb.push_back(mdl[3]); sb.push_back(mdl[5]); sb.push_back(DW'(mcnt[CW-1:0]));
    #1;
    exp_v = sb.pop_front(); checks++;
    if (vall !== exp_v) begin errors++; $display("FAIL rst_r3 got %h exp %h", vall, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (dbgv !== exp_v) begin errors++; $display("FAIL rst_r5_cleared got %h exp %h", dbgv, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (DW'(wcnt) !== exp_v) begin errors++; $display("FAIL rst_count got %h exp %h", wcnt, exp_v); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 16; i++) begin
      we = 1'b1; wa = AW'(i); wv = $urandom; la = AW'(i); ra = AW'(i - 1); da = AW'(i);
      sb.push_back(wv); sb.push_back(mdl[i - 1]); sb.push_back(mdl[i]);
      #1;
      exp_v = sb.pop_front(); checks++;
      if (vall !== exp_v) begin errors++; $display("FAIL b2b_left i=%0d got %h exp %h", i, vall, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (valr !== exp_v) begin errors++; $display("FAIL b2b_right i=%0d got %h exp %h", i, valr, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (dbgv !== exp_v) begin errors++; $display("FAIL b2b_dbg i=%0d got %h exp %h", i, dbgv, exp_v); end
      step(); model_commit();
    end
    we = 1'b0;
    sb.push_back(DW'(mcnt[CW-1:0]));
    #1;
    exp_v = sb.pop_front(); checks++;
    if (DW'(wcnt) !== exp_v) begin errors++; $display("FAIL b2b_count got %h exp %h", wcnt, exp_v); end
  endtask

  task automatic test_wrap();
    we = 1'b1; wa = 5'd1; wv = 32'h0BADF00D;
    step(); model_commit();
    we = 1'b0; da = 5'd1;
    sb.push_back(DW'(mcnt[CW-1:0])); sb.push_back(mdl[1]);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (DW'(wcnt) !== exp_v) begin errors++; $display("FAIL wrap_count got %h exp %h", wcnt, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (dbgv !== exp_v) begin errors++; $display("FAIL wrap_r1 got %h exp %h", dbgv, exp_v); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mcnt = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_reset_write();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
